// File: rtl/pwm_rgb_pkg.sv
// Shared definitions for the AXI4-Lite RGB PWM block: register map, CTRL bits,
// response codes, bus FSM states and the address decoder.
package pwm_rgb_pkg;

  localparam logic [11:0] CTRL_OFFS     = 12'h000;
  localparam logic [11:0] PRESCALE_OFFS = 12'h004;
  localparam logic [11:0] STATUS_OFFS   = 12'h008;
  localparam logic [11:0] LED_BASE      = 12'h010;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  localparam int COL_R = 2;
  localparam int COL_G = 1;
  localparam int COL_B = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRESP,
    ST_RDATA
  } axi_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_PRESCALE,
    SEL_STATUS,
    SEL_LED
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] idx;
  } reg_dec_t;

  // Misaligned addresses fall outside the map and answer SLVERR.
  function automatic reg_dec_t decode_addr(input logic [11:0] addr, input int nled);
    reg_dec_t   dec;
    logic [9:0] word;
    logic [9:0] led_word;
    dec.sel  = SEL_NONE;
    dec.idx  = 3'd0;
    word     = addr[11:2];
    led_word = word - LED_BASE[11:2];
    if (addr[1:0] != 2'b00)                dec.sel = SEL_NONE;
    else if (word == CTRL_OFFS[11:2])      dec.sel = SEL_CTRL;
    else if (word == PRESCALE_OFFS[11:2])  dec.sel = SEL_PRESCALE;
    else if (word == STATUS_OFFS[11:2])    dec.sel = SEL_STATUS;
    else if (word >= LED_BASE[11:2] && led_word < 10'(nled)) begin
      dec.sel = SEL_LED;
      dec.idx = led_word[2:0];
    end
    return dec;
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] word;
    word = old_word;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
    end
    return word;
  endfunction

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bundle for the 4 KiB ledrgb window: 12-bit address, 32-bit data.
interface axi4l_if;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pwm_rgb_channel.sv
// One RGB LED: shadow duties loaded at period boundaries, compared against the
// shared PWM count, registered pin outputs.
module pwm_rgb_channel #(
  parameter int CW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               inv,
  input  logic               load,
  input  logic [CW-1:0]      cnt,
  input  logic [2:0][CW-1:0] duty,
  output logic [2:0]         rgb
);

  logic [2:0][CW-1:0] shadow;

  // NOTE: shadow duties are plain flops, so they take the async reset like all other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      rgb    <= '0;
    end else begin
      if (load) shadow <= duty;
      // NOTE: <= makes every flop sample pre-edge values regardless of statement order.
      for (int c = 0; c < 3; c++) begin
        rgb[c] <= inv ^ (en && (cnt < shadow[c]));
      end
    end
  end

endmodule

// File: rtl/axi4l_pwm_rgb.sv
// AXI4-Lite slave with per-colour PWM for NLED RGB LEDs: bus FSM, register
// file, prescaler and shared PWM counter; per-LED compare in pwm_rgb_channel.
module axi4l_pwm_rgb
  import pwm_rgb_pkg::*;
#(
  parameter int NLED = 4,
  parameter int CW   = 8,
  parameter int PSW  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  axi4l_if.slave               axi,
  output logic [NLED-1:0][2:0] ledrgb
);

  axi_state_e state, state_nxt;
  logic       wr_go, rd_go;
  reg_dec_t   wr_dec, rd_dec;

  logic                         ctrl_en, ctrl_inv;
  logic [PSW-1:0]               prescale, pcnt;
  logic [CW-1:0]                cnt;
  logic [NLED-1:0][2:0][CW-1:0] duty;

  logic [31:0] wr_old, wr_new, rd_word;
  logic [31:0] rdata_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        tick, shadow_load;

  assign wr_dec = decode_addr(axi.awaddr, NLED);
  assign rd_dec = decode_addr(axi.araddr, NLED);

  function automatic logic [31:0] read_reg(input reg_dec_t dec);
    logic [31:0] word;
    word = '0;
    case (dec.sel)
      SEL_CTRL: begin
        word[CTRL_EN_BIT]  = ctrl_en;
        word[CTRL_INV_BIT] = ctrl_inv;
      end
      SEL_PRESCALE: word[PSW-1:0] = prescale;
      SEL_STATUS:   word[CW-1:0]  = cnt;
      SEL_LED: begin
        for (int i = 0; i < NLED; i++) begin
          if (dec.idx == 3'(i)) begin
            word[16 +: CW] = duty[i][COL_R];
            word[8 +: CW]  = duty[i][COL_G];
            word[0 +: CW]  = duty[i][COL_B];
          end
        end
      end
      default: word = '0;
    endcase
    return word;
  endfunction

  assign wr_old  = read_reg(wr_dec);
  assign rd_word = read_reg(rd_dec);
  assign wr_new  = apply_wstrb(wr_old, axi.wdata, axi.wstrb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output gets a default first, so no branch can leave a latch behind.
  always_comb begin
    state_nxt   = state;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.arready = 1'b0;
    axi.bvalid  = 1'b0;
    axi.rvalid  = 1'b0;
    wr_go       = 1'b0;
    rd_go       = 1'b0;
    case (state)
      ST_IDLE: begin
        // A complete write pair outranks a pending read.
        if (axi.awvalid && axi.wvalid) begin
          axi.awready = 1'b1;
          axi.wready  = 1'b1;
          wr_go       = 1'b1;
          state_nxt   = ST_WRESP;
        end else if (axi.arvalid) begin
          axi.arready = 1'b1;
          rd_go       = 1'b1;
          state_nxt   = ST_RDATA;
        end
      end
      ST_WRESP: begin
        axi.bvalid = 1'b1;
        if (axi.bready) state_nxt = ST_IDLE;
      end
      ST_RDATA: begin
        axi.rvalid = 1'b1;
        if (axi.rready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign axi.bresp = bresp_q;
  assign axi.rresp = rresp_q;
  assign axi.rdata = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      if (wr_go) bresp_q <= (wr_dec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      if (rd_go) begin
        rdata_q <= rd_word;
        rresp_q <= (rd_dec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en  <= 1'b0;
      ctrl_inv <= 1'b0;
      prescale <= '0;
      duty     <= '0;
    end else if (wr_go) begin
      case (wr_dec.sel)
        SEL_CTRL: begin
          ctrl_en  <= wr_new[CTRL_EN_BIT];
          ctrl_inv <= wr_new[CTRL_INV_BIT];
        end
        SEL_PRESCALE: prescale <= wr_new[PSW-1:0];
        SEL_LED: begin
          for (int i = 0; i < NLED; i++) begin
            if (wr_dec.idx == 3'(i)) begin
              duty[i][COL_R] <= wr_new[16 +: CW];
              duty[i][COL_G] <= wr_new[8 +: CW];
              duty[i][COL_B] <= wr_new[0 +: CW];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ">=" also catches PRESCALE lowered below a running pcnt: tick now, restart.
  assign tick        = ctrl_en && (pcnt >= prescale);
  assign shadow_load = !ctrl_en || (tick && (cnt == {CW{1'b1}}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (!ctrl_en) begin
      pcnt <= '0;
      cnt  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      cnt  <= cnt + CW'(1);
    end else begin
      pcnt <= pcnt + PSW'(1);
    end
  end

  for (genvar i = 0; i < NLED; i++) begin : g_led
    pwm_rgb_channel #(.CW(CW)) u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (ctrl_en),
      .inv  (ctrl_inv),
      .load (shadow_load),
      .cnt  (cnt),
      .duty (duty[i]),
      .rgb  (ledrgb[i])
    );
  end

endmodule

// File: tb/tb_axi4l_pwm_rgb.sv
// Self-checking bench for axi4l_pwm_rgb: register-map model, randomized bus
// traffic, and duty/period measurements taken from the LED pins.
module tb_axi4l_pwm_rgb;
  import pwm_rgb_pkg::*;

  localparam int NLED    = 4;
  localparam int CW      = 8;
  localparam int PSW     = 16;
  localparam int TIMEOUT = 64;

  logic                 clk;
  logic                 rst;
  logic [NLED-1:0][2:0] ledrgb;

  axi4l_if axi_bus ();

  axi4l_pwm_rgb #(.NLED(NLED), .CW(CW), .PSW(PSW)) dut (
    .clk    (clk),
    .rst    (rst),
    .axi    (axi_bus),
    .ledrgb (ledrgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Register contents as the bus should see them, indexed by word address.
  logic [31:0] model_reg [0:1023];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [11:0] led_addr(input int i);
    return 12'h010 + 12'(4 * i);
  endfunction

  function automatic logic [31:0] model_mask(input logic [11:0] a, output bit mapped);
    mapped = 1'b1;
    if (a[1:0] != 2'b00) begin
      mapped = 1'b0;
      return 32'h0;
    end
    if (a == 12'h000) return 32'h0000_0003;
    if (a == 12'h004) return 32'h0000_FFFF;
    if (a == 12'h008) return 32'h0;
    if (a >= 12'h010 && int'(a) < 16 + 4 * NLED) return 32'h00FF_FFFF;
    mapped = 1'b0;
    return 32'h0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 1024; k++) model_reg[k] = 32'h0;
  endfunction

  function automatic logic [1:0] model_write(input logic [11:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    bit          mapped;
    logic [31:0] m;
    m = model_mask(a, mapped);
    if (!mapped) return RESP_SLVERR;
    m = m & {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    model_reg[a[11:2]] = (model_reg[a[11:2]] & ~m) | (d & m);
    return RESP_OKAY;
  endfunction

  function automatic logic [1:0] model_read(input logic [11:0] a, input logic [31:0] status,
                                            output logic [31:0] d);
    bit          mapped;
    logic [31:0] m;
    m = model_mask(a, mapped);
    d = 32'h0;
    if (!mapped) return RESP_SLVERR;
    d = (a == 12'h008) ? status : model_reg[a[11:2]];
    return RESP_OKAY;
  endfunction

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int t;
    @(negedge clk);
    axi_bus.awaddr  = a;
    axi_bus.wdata   = d;
    axi_bus.wstrb   = s;
    axi_bus.awvalid = 1'b1;
    axi_bus.wvalid  = 1'b1;
    #1;
    t = 0;
    while (!(axi_bus.awready && axi_bus.wready) && t < TIMEOUT) begin
      @(negedge clk); #1; t++;
    end
    check("aw/w handshake", 32'(axi_bus.awready && axi_bus.wready), 32'd1);
    @(negedge clk);
    axi_bus.awvalid = 1'b0;
    axi_bus.wvalid  = 1'b0;
    axi_bus.bready  = 1'b1;
    #1;
    t = 0;
    while (!axi_bus.bvalid && t < TIMEOUT) begin
      @(negedge clk); #1; t++;
    end
    check("bvalid", 32'(axi_bus.bvalid), 32'd1);
    resp = axi_bus.bresp;
    @(negedge clk);
    axi_bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int t;
    @(negedge clk);
    axi_bus.araddr  = a;
    axi_bus.arvalid = 1'b1;
    #1;
    t = 0;
    while (!axi_bus.arready && t < TIMEOUT) begin
      @(negedge clk); #1; t++;
    end
    check("ar handshake", 32'(axi_bus.arready), 32'd1);
    @(negedge clk);
    axi_bus.arvalid = 1'b0;
    axi_bus.rready  = 1'b1;
    #1;
    t = 0;
    while (!axi_bus.rvalid && t < TIMEOUT) begin
      @(negedge clk); #1; t++;
    end
    check("rvalid", 32'(axi_bus.rvalid), 32'd1);
    d    = axi_bus.rdata;
    resp = axi_bus.rresp;
    @(negedge clk);
    axi_bus.rready = 1'b0;
  endtask

  task automatic reg_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] resp;
    logic [1:0] exp_resp;
    axi_write(a, d, s, resp);
    exp_resp = model_write(a, d, s);
    check($sformatf("bresp @%03h", a), 32'(resp), 32'(exp_resp));
  endtask

  task automatic reg_read(input logic [11:0] a, input logic [31:0] status);
    logic [31:0] d, exp_d;
    logic [1:0]  resp, exp_resp;
    axi_read(a, d, resp);
    exp_resp = model_read(a, status, exp_d);
    check($sformatf("rdata @%03h", a), d, exp_d);
    check($sformatf("rresp @%03h", a), 32'(resp), 32'(exp_resp));
  endtask

  // Returns at the negedge where LED0 red (duty 1, the period marker) rises.
  task automatic wait_marker();
    logic prev;
    bit   found;
    prev  = ledrgb[0][COL_R];
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (ledrgb[0][COL_R] && !prev) begin
        found = 1'b1;
        break;
      end
      prev = ledrgb[0][COL_R];
    end
    check("period marker seen", 32'(found), 32'd1);
  endtask

  task automatic measure_interval(output int n);
    logic prev;
    prev = ledrgb[0][COL_R];
    n    = 0;
    for (int k = 1; k < 3000; k++) begin
      @(negedge clk);
      if (ledrgb[0][COL_R] && !prev) begin
        n = k;
        break;
      end
      prev = ledrgb[0][COL_R];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    logic [31:0] s1, s2;
    logic [7:0]  duty_tb [NLED][3];
    int          on_cnt  [NLED][3];
    int          t, n;
    int          win_a, win_b;
    logic [NLED*3-1:0] all_on;

    all_on = '1;
    rst = 1'b1;
    axi_bus.awaddr = '0; axi_bus.awvalid = 1'b0; axi_bus.wdata = '0; axi_bus.wstrb = '0;
    axi_bus.wvalid = 1'b0; axi_bus.bready = 1'b0; axi_bus.araddr = '0; axi_bus.arvalid = 1'b0;
    axi_bus.rready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ledrgb", 32'(ledrgb), 32'd0);
    check("reset bvalid", 32'(axi_bus.bvalid), 32'd0);
    check("reset rvalid", 32'(axi_bus.rvalid), 32'd0);

    // Reset in the middle of a read: response dropped, registers cleared.
    reg_write(12'h000, 32'h2, 4'hF);
    repeat (3) @(negedge clk);
    check("inv with en=0 lights all", 32'(ledrgb), 32'(all_on));
    @(negedge clk);
    axi_bus.araddr  = 12'h000;
    axi_bus.arvalid = 1'b1;
    #1;
    t = 0;
    while (!axi_bus.arready && t < TIMEOUT) begin @(negedge clk); #1; t++; end
    @(negedge clk);
    axi_bus.arvalid = 1'b0;
    #1;
    check("rvalid before reset", 32'(axi_bus.rvalid), 32'd1);
    rst = 1'b1;
    #1;
    check("rvalid dropped by reset", 32'(axi_bus.rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("ledrgb after reset", 32'(ledrgb), 32'd0);
    reg_read(12'h000, 32'h0);

    // Error responses and byte strobes.
    reg_read(12'h0FC, 32'h0);
    reg_write(led_addr(NLED), 32'hFFFF_FFFF, 4'hF);
    reg_write(12'h006, 32'h1234_5678, 4'hF);
    for (int i = 0; i < NLED; i++) reg_read(led_addr(i), 32'h0);
    reg_read(12'h004, 32'h0);
    reg_write(led_addr(0), 32'h0011_2233, 4'hF);
    reg_write(led_addr(0), 32'hAABB_CCDD, 4'b0010);
    reg_read(led_addr(0), 32'h0);
    reg_write(12'h008, 32'hFFFF_FFFF, 4'hF);
    reg_read(12'h008, 32'h0);

    // Randomized register traffic; CTRL stays 0 so STATUS must read 0.
    for (int k = 0; k < 40; k++) begin
      logic [11:0] a;
      case ($urandom_range(0, 3))
        0:       a = 12'h004;
        1:       a = 12'h008;
        2:       a = led_addr($urandom_range(0, NLED - 1));
        default: a = 12'($urandom_range(1, 1023) << 2);
      endcase
      if ($urandom_range(0, 1) == 0) reg_write(a, $urandom, 4'($urandom_range(0, 15)));
      else                           reg_read(a, 32'h0);
    end
    for (int i = 0; i < NLED; i++) reg_read(led_addr(i), 32'h0);
    reg_read(12'h004, 32'h0);

    // Write, write data and read presented together: write first, read after bready.
    @(negedge clk);
    axi_bus.awaddr  = led_addr(2);
    axi_bus.wdata   = 32'h00C3_5A81;
    axi_bus.wstrb   = 4'hF;
    axi_bus.awvalid = 1'b1;
    axi_bus.wvalid  = 1'b1;
    axi_bus.araddr  = led_addr(2);
    axi_bus.arvalid = 1'b1;
    #1;
    check("collision write accepted", 32'(axi_bus.awready && axi_bus.wready), 32'd1);
    check("collision read held off", 32'(axi_bus.arready), 32'd0);
    void'(model_write(led_addr(2), 32'h00C3_5A81, 4'hF));
    @(negedge clk);
    axi_bus.awvalid = 1'b0;
    axi_bus.wvalid  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bvalid held %0d", k), 32'(axi_bus.bvalid), 32'd1);
      check($sformatf("arready low in wresp %0d", k), 32'(axi_bus.arready), 32'd0);
      @(negedge clk);
    end
    axi_bus.bready = 1'b1;
    @(negedge clk);
    axi_bus.bready = 1'b0;
    #1;
    check("bvalid cleared", 32'(axi_bus.bvalid), 32'd0);
    check("queued read accepted", 32'(axi_bus.arready), 32'd1);
    @(negedge clk);
    axi_bus.arvalid = 1'b0;
    axi_bus.rready  = 1'b1;
    #1;
    check("queued read rvalid", 32'(axi_bus.rvalid), 32'd1);
    void'(model_read(led_addr(2), 32'h0, d));
    check("queued read data", axi_bus.rdata, d);
    check("queued read resp", 32'(axi_bus.rresp), 32'(RESP_OKAY));
    @(negedge clk);
    axi_bus.rready = 1'b0;

    // Duty cycles measured over whole periods with random duties and prescale.
    for (int it = 0; it < 3; it++) begin
      int p, period;
      bit inv;
      p      = (it == 0) ? 0 : $urandom_range(1, 2);
      inv    = (it == 1);
      period = 256 * (p + 1);
      reg_write(12'h000, 32'h0, 4'hF);
      for (int i = 0; i < NLED; i++)
        for (int c = 0; c < 3; c++) duty_tb[i][c] = 8'($urandom_range(0, 255));
      if (it == 0) begin
        duty_tb[0][COL_R] = 8'h00;
        duty_tb[0][COL_G] = 8'h80;
        duty_tb[0][COL_B] = 8'h40;
      end
      duty_tb[NLED-1][COL_B] = 8'hFF;
      duty_tb[NLED-2][COL_B] = 8'h00;
      for (int i = 0; i < NLED; i++)
        reg_write(led_addr(i), {8'h00, duty_tb[i][COL_R], duty_tb[i][COL_G], duty_tb[i][COL_B]}, 4'hF);
      reg_write(12'h004, 32'(p), 4'hF);
      reg_write(12'h000, {30'h0, inv, 1'b1}, 4'hF);
      if (it == 0) begin
        axi_read(12'h008, s1, resp);
        axi_read(12'h008, s2, resp);
        check("status advances", 32'(s1 != s2), 32'd1);
        check("status resp", 32'(resp), 32'(RESP_OKAY));
      end
      repeat (4) @(negedge clk);
      for (int i = 0; i < NLED; i++)
        for (int c = 0; c < 3; c++) on_cnt[i][c] = 0;
      for (int k = 0; k < period; k++) begin
        @(negedge clk);
        for (int i = 0; i < NLED; i++)
          for (int c = 0; c < 3; c++) on_cnt[i][c] += int'(ledrgb[i][c]);
      end
      for (int i = 0; i < NLED; i++)
        for (int c = 0; c < 3; c++) begin
          int exp_on;
          exp_on = int'(duty_tb[i][c]) * (p + 1);
          if (inv) exp_on = period - exp_on;
          check($sformatf("on-count it%0d led%0d col%0d", it, i, c), 32'(on_cnt[i][c]), 32'(exp_on));
        end
    end
    reg_write(12'h000, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    check("disabled ledrgb", 32'(ledrgb), 32'd0);

    // Mid-period duty change only takes effect from the next period.
    reg_write(led_addr(0), 32'h0001_0000, 4'hF);
    reg_write(led_addr(1), 32'h0000_8000, 4'hF);
    reg_write(12'h004, 32'h0, 4'hF);
    reg_write(12'h000, 32'h1, 4'hF);
    wait_marker();
    win_a = 0;
    win_b = 0;
    fork
      begin
        for (int k = 0; k < 256; k++) begin
          if (k > 0) @(negedge clk);
          win_a += int'(ledrgb[1][COL_G]);
        end
      end
      begin
        repeat (8'h40) @(negedge clk);
        reg_write(led_addr(1), 32'h0000_1000, 4'hF);
      end
    join
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      win_b += int'(ledrgb[1][COL_G]);
    end
    check("old duty kept for current period", 32'(win_a), 32'd128);
    check("new duty from next period", 32'(win_b), 32'd16);

    // Prescaler: period scales with PRESCALE+1, and follows a lowered PRESCALE.
    reg_write(12'h000, 32'h0, 4'hF);
    reg_write(led_addr(0), 32'h0001_2A00, 4'hF);
    reg_write(12'h004, 32'h3, 4'hF);
    reg_write(12'h000, 32'h1, 4'hF);
    wait_marker();
    win_a = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k > 0) @(negedge clk);
      win_a += int'(ledrgb[0][COL_G]);
    end
    check("prescale 3 on-count", 32'(win_a), 32'd168);
    wait_marker();
    measure_interval(n);
    check("prescale 3 period", 32'(n), 32'd1024);
    reg_write(12'h004, 32'h1, 4'hF);
    wait_marker();
    measure_interval(n);
    check("prescale 1 period", 32'(n), 32'd512);
    reg_read(12'h004, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
